// File: rtl/arcade_input_mapper.sv
// Player-input front end: latches hps_io PS/2 key events, ORs them with joystick
// words, and adds fire-1 autofire and coin pulse stretching per player.
module arcade_input_mapper #(
  parameter int PLAYERS   = 2,
  parameter int AF_HALF   = 200000,
  parameter int COIN_HOLD = 1200000
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joy_in,
  input  logic [PLAYERS-1:0]     autofire_en,
  output logic [8*PLAYERS-1:0]   btn,
  output logic                   btn_test
);

  localparam int AFW = $clog2(AF_HALF + 1);
  localparam int CW  = $clog2(COIN_HOLD + 1);

  // key_q layout: [7:0] P1 vector, [15:8] P2 vector (start2/coin2 at 14/15), [16] test
  logic        tog_q;
  logic [16:0] key_q;
  logic [16:0] key_hit;
  logic        key_evt;
  logic        ext;

  assign key_evt = ps2_key[10] ^ tog_q;
  assign ext     = ps2_key[8];

  always_comb begin
    key_hit = '0;
    case (ps2_key[7:0])
      8'h74:        key_hit[0]  = 1'b1;
      8'h6B:        key_hit[1]  = 1'b1;
      8'h72:        key_hit[2]  = 1'b1;
      8'h75:        key_hit[3]  = 1'b1;
      8'h29:        key_hit[4]  = !ext;
      8'h14:        key_hit[5]  = !ext;
      8'h16, 8'h05: key_hit[6]  = !ext;
      8'h2E:        key_hit[7]  = !ext;
      8'h34:        key_hit[8]  = !ext;
      8'h23:        key_hit[9]  = !ext;
      8'h2B:        key_hit[10] = !ext;
      8'h2D:        key_hit[11] = !ext;
      8'h1C:        key_hit[12] = !ext;
      8'h1B:        key_hit[13] = !ext;
      8'h1E, 8'h06: key_hit[14] = !ext;
      8'h36:        key_hit[15] = !ext;
      8'h2C:        key_hit[16] = !ext;
      default:      key_hit     = '0;
    endcase
  end

  // tog_q reloads during reset so that releasing reset never looks like an event
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tog_q    <= ps2_key[10];
      key_q    <= '0;
      btn_test <= 1'b0;
    end else begin
      tog_q <= ps2_key[10];
      if (key_evt)
        key_q <= (key_q & ~key_hit) | (key_hit & {17{ps2_key[9]}});
      btn_test <= key_q[16];
    end
  end

  logic unused_keys;
  assign unused_keys = ^key_q;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [7:0]     key_src;
    logic [7:0]     raw;
    logic [7:0]     btn_q;
    logic [AFW-1:0] af_cnt;
    logic           af_phase;
    logic [CW-1:0]  coin_cnt;
    logic           coin_q;
    logic           unused_joy;

    if (p == 0) begin : g_src0
      if (PLAYERS == 1) begin : g_solo
        assign key_src = key_q[7:0] | {key_q[15:14], 6'b0};
      end else begin : g_multi
        assign key_src = key_q[7:0];
      end
    end else if (p == 1) begin : g_src1
      assign key_src = key_q[15:8];
    end else begin : g_src_joy
      assign key_src = '0;
    end

    assign raw        = key_src | joy_in[16*p +: 8];
    assign unused_joy = ^joy_in[16*p+8 +: 8];
    assign btn[8*p +: 8] = btn_q;

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        af_cnt   <= '0;
        af_phase <= 1'b1;
        coin_cnt <= '0;
        coin_q   <= 1'b0;
        btn_q    <= '0;
      end else begin
        // phase restarts high on every fresh press and flips every AF_HALF held clocks
        if (!raw[4]) begin
          af_cnt   <= '0;
          af_phase <= 1'b1;
        end else if (af_cnt == AFW'(AF_HALF - 1)) begin
          af_cnt   <= '0;
          af_phase <= ~af_phase;
        end else begin
          af_cnt <= af_cnt + AFW'(1);
        end

        coin_q <= raw[7];
        if (raw[7] && !coin_q)
          coin_cnt <= CW'(COIN_HOLD);
        else if (coin_cnt != '0)
          coin_cnt <= coin_cnt - CW'(1);

        btn_q <= {raw[7] | (coin_cnt != '0),
                  raw[6:5],
                  autofire_en[p] ? (raw[4] & af_phase) : raw[4],
                  raw[3:0]};
      end
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios plus randomized traffic checked
// against a table-driven behavioural model (two configurations: 2 players and 1).
module tb_arcade_input_mapper;

  localparam int AF = 4;
  localparam int CH = 10;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joy2;
  logic [15:0] joy1;
  logic [1:0]  af2;
  logic        af1;
  logic [15:0] btn2;
  logic [7:0]  btn1;
  logic        test2, test1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(.PLAYERS(2), .AF_HALF(AF), .COIN_HOLD(CH)) u_dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy2),
    .autofire_en(af2), .btn(btn2), .btn_test(test2));

  arcade_input_mapper #(.PLAYERS(1), .AF_HALF(AF), .COIN_HOLD(CH)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy1),
    .autofire_en(af1), .btn(btn1), .btn_test(test1));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] code;
    bit         any_ext;
    int         player;   // 0, 1, or 2 for the test key
    int         bitn;
  } map_t;

  map_t km [19] = '{
    '{8'h75, 1'b1, 0, 3}, '{8'h72, 1'b1, 0, 2}, '{8'h6B, 1'b1, 0, 1}, '{8'h74, 1'b1, 0, 0},
    '{8'h29, 1'b0, 0, 4}, '{8'h14, 1'b0, 0, 5}, '{8'h16, 1'b0, 0, 6}, '{8'h05, 1'b0, 0, 6},
    '{8'h1E, 1'b0, 1, 6}, '{8'h06, 1'b0, 1, 6}, '{8'h2E, 1'b0, 0, 7}, '{8'h36, 1'b0, 1, 7},
    '{8'h2D, 1'b0, 1, 3}, '{8'h2B, 1'b0, 1, 2}, '{8'h23, 1'b0, 1, 1}, '{8'h34, 1'b0, 1, 0},
    '{8'h1C, 1'b0, 1, 4}, '{8'h1B, 1'b0, 1, 5}, '{8'h2C, 1'b0, 2, 0}
  };

  bit   ks [3][8];
  int   afk [2][2];
  int   last_rise [2][2];
  bit   had_rise [2][2];
  bit   prev_coin [2][2];
  bit   tog_m;
  int   ncyc = 0;
  logic [15:0] exp_btn2;
  logic [7:0]  exp_btn1;
  logic        exp_test;

  function automatic logic [7:0] src_of(int np, int p);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      v[b] = ks[p][b];
      if (np == 1 && p == 0 && b >= 6) v[b] = v[b] | ks[1][b];
    end
    return v;
  endfunction

  always @(posedge clk_sys) begin
    if (!reset_n) begin
      foreach (ks[i, j]) ks[i][j] = 1'b0;
      foreach (afk[i, j]) begin
        afk[i][j] = 0; had_rise[i][j] = 1'b0; prev_coin[i][j] = 1'b0; last_rise[i][j] = 0;
      end
      tog_m    = ps2_key[10];
      exp_btn2 = '0;
      exp_btn1 = '0;
      exp_test = 1'b0;
    end else begin
      for (int cfg = 0; cfg < 2; cfg++) begin
        int np;
        np = (cfg == 0) ? 2 : 1;
        for (int p = 0; p < np; p++) begin
          logic [7:0] raw, e;
          bit en;
          raw = src_of(np, p) | ((cfg == 0) ? joy2[16*p +: 8] : joy1[7:0]);
          en  = (cfg == 0) ? af2[p] : af1;
          e   = raw;
          e[4] = raw[4] && (!en || ((afk[cfg][p] / AF) % 2 == 0));
          afk[cfg][p] = raw[4] ? afk[cfg][p] + 1 : 0;
          if (raw[7] && !prev_coin[cfg][p]) begin
            last_rise[cfg][p] = ncyc;
            had_rise[cfg][p]  = 1'b1;
          end
          prev_coin[cfg][p] = raw[7];
          e[7] = raw[7] || (had_rise[cfg][p] && (ncyc - last_rise[cfg][p] <= CH));
          if (cfg == 0) exp_btn2[8*p +: 8] = e;
          else          exp_btn1 = e;
        end
      end
      exp_test = ks[2][0];
      if (ps2_key[10] != tog_m)
        foreach (km[i])
          if (km[i].code == ps2_key[7:0] && (km[i].any_ext || !ps2_key[8]))
            ks[km[i].player][km[i].bitn] = ps2_key[9];
      tog_m = ps2_key[10];
    end
    ncyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_key(input bit pressed, input bit e, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, e, code};
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    cycles(2);
    n_checks++; if (btn2 !== 16'h0) begin n_fail++; $display("FAIL reset_btn2: got %h want %h", btn2, 16'h0); end
    n_checks++; if (btn1 !== 8'h0) begin n_fail++; $display("FAIL reset_btn1: got %h want %h", btn1, 8'h0); end
    reset_n = 1'b1;
    cycles(3);
    n_checks++; if (btn2 !== 16'h0) begin n_fail++; $display("FAIL reset_no_event: got %h want %h", btn2, 16'h0); end
    n_checks++; if (test2 !== 1'b0) begin n_fail++; $display("FAIL reset_test: got %b want %b", test2, 1'b0); end
  endtask

  task automatic test_key_press();
    send_key(1'b1, 1'b0, 8'h75);
    cycles(1);
    n_checks++; if (btn2[3] !== 1'b0) begin n_fail++; $display("FAIL up_latency1: got %b want %b", btn2[3], 1'b0); end
    cycles(1);
    n_checks++; if (btn2[3] !== 1'b1) begin n_fail++; $display("FAIL up_press: got %b want %b", btn2[3], 1'b1); end
    n_checks++; if (btn1[3] !== 1'b1) begin n_fail++; $display("FAIL up_press_p1cfg: got %b want %b", btn1[3], 1'b1); end
    cycles(3);
    n_checks++; if (btn2[3] !== 1'b1) begin n_fail++; $display("FAIL up_held: got %b want %b", btn2[3], 1'b1); end
    send_key(1'b0, 1'b0, 8'h75);
    cycles(2);
    n_checks++; if (btn2[3] !== 1'b0) begin n_fail++; $display("FAIL up_release: got %b want %b", btn2[3], 1'b0); end
    send_key(1'b1, 1'b1, 8'h75);
    cycles(2);
    n_checks++; if (btn2[3] !== 1'b1) begin n_fail++; $display("FAIL up_ext_press: got %b want %b", btn2[3], 1'b1); end
    send_key(1'b0, 1'b1, 8'h75);
    cycles(2);
    n_checks++; if (btn2[3] !== 1'b0) begin n_fail++; $display("FAIL up_ext_release: got %b want %b", btn2[3], 1'b0); end
    send_key(1'b1, 1'b1, 8'h14);
    cycles(2);
    n_checks++; if (btn2 !== 16'h0) begin n_fail++; $display("FAIL ext_fire2_ignored: got %h want %h", btn2, 16'h0); end
    send_key(1'b1, 1'b0, 8'h2C);
    cycles(2);
    n_checks++; if (test2 !== 1'b1) begin n_fail++; $display("FAIL test_key: got %b want %b", test2, 1'b1); end
    send_key(1'b0, 1'b0, 8'h2C);
    cycles(2);
    n_checks++; if (test2 !== 1'b0) begin n_fail++; $display("FAIL test_key_release: got %b want %b", test2, 1'b0); end
  endtask

  task automatic test_p2_routing();
    send_key(1'b1, 1'b0, 8'h2B);
    cycles(2);
    n_checks++; if (btn2[10] !== 1'b1) begin n_fail++; $display("FAIL p2_down: got %b want %b", btn2[10], 1'b1); end
    n_checks++; if (btn2[2] !== 1'b0) begin n_fail++; $display("FAIL p2_down_not_p1: got %b want %b", btn2[2], 1'b0); end
    n_checks++; if (btn1 !== 8'h0) begin n_fail++; $display("FAIL p2_ignored_solo: got %h want %h", btn1, 8'h0); end
    send_key(1'b0, 1'b0, 8'h2B);
    cycles(2);
    send_key(1'b1, 1'b0, 8'h36);
    cycles(1);
    send_key(1'b0, 1'b0, 8'h36);
    for (int i = 0; i < CH + 1; i++) begin
      cycles(1);
      n_checks++; if (btn1[7] !== 1'b1) begin n_fail++; $display("FAIL coin2_solo_stretch[%0d]: got %b want %b", i, btn1[7], 1'b1); end
      n_checks++; if (btn2[15] !== 1'b1) begin n_fail++; $display("FAIL coin2_p2_stretch[%0d]: got %b want %b", i, btn2[15], 1'b1); end
    end
    cycles(1);
    n_checks++; if (btn1[7] !== 1'b0) begin n_fail++; $display("FAIL coin2_solo_end: got %b want %b", btn1[7], 1'b0); end
    n_checks++; if (btn2[7] !== 1'b0) begin n_fail++; $display("FAIL coin2_not_p1: got %b want %b", btn2[7], 1'b0); end
  endtask

  task automatic test_or_merge();
    send_key(1'b1, 1'b0, 8'h75);
    cycles(2);
    joy2[3] = 1'b1;
    cycles(1);
    joy2[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      n_checks++; if (btn2[3] !== 1'b1) begin n_fail++; $display("FAIL or_hold[%0d]: got %b want %b", i, btn2[3], 1'b1); end
    end
    send_key(1'b0, 1'b0, 8'h75);
    cycles(1);
    n_checks++; if (btn2[3] !== 1'b1) begin n_fail++; $display("FAIL or_release_lat: got %b want %b", btn2[3], 1'b1); end
    cycles(1);
    n_checks++; if (btn2[3] !== 1'b0) begin n_fail++; $display("FAIL or_release: got %b want %b", btn2[3], 1'b0); end
  endtask

  task automatic test_autofire();
    logic [19:0] pat;
    pat = 20'b1111_0000_1111_0000_1111;
    af2[0] = 1'b1;
    af1    = 1'b1;
    joy2[4] = 1'b1;
    joy1[4] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      n_checks++; if (btn2[4] !== pat[19-i]) begin n_fail++; $display("FAIL autofire[%0d]: got %b want %b", i, btn2[4], pat[19-i]); end
      n_checks++; if (btn1[4] !== pat[19-i]) begin n_fail++; $display("FAIL autofire_solo[%0d]: got %b want %b", i, btn1[4], pat[19-i]); end
    end
    joy2[4] = 1'b0;
    joy1[4] = 1'b0;
    cycles(1);
    n_checks++; if (btn2[4] !== 1'b0) begin n_fail++; $display("FAIL autofire_release: got %b want %b", btn2[4], 1'b0); end
    af2 = '0;
    af1 = 1'b0;
    joy2[4] = 1'b1;
    cycles(6);
    n_checks++; if (btn2[4] !== 1'b1) begin n_fail++; $display("FAIL autofire_off: got %b want %b", btn2[4], 1'b1); end
    joy2[4] = 1'b0;
    cycles(1);
  endtask

  task automatic test_coin();
    joy2[7] = 1'b1;
    cycles(1);
    joy2[7] = 1'b0;
    n_checks++; if (btn2[7] !== 1'b1) begin n_fail++; $display("FAIL coin_first: got %b want %b", btn2[7], 1'b1); end
    for (int s = 2; s <= CH + 2; s++) begin
      cycles(1);
      n_checks++; if (btn2[7] !== (s <= CH + 1)) begin n_fail++; $display("FAIL coin_single[%0d]: got %b want %b", s, btn2[7], (s <= CH + 1)); end
    end
    cycles(2);
    for (int c = 0; c < 18; c++) begin
      joy2[7] = (c == 0 || c == 5);
      cycles(1);
      n_checks++; if (btn2[7] !== (c + 1 <= 16)) begin n_fail++; $display("FAIL coin_retrig[%0d]: got %b want %b", c + 1, btn2[7], (c + 1 <= 16)); end
    end
    joy2[7] = 1'b1;
    cycles(1);
    joy2[7] = 1'b0;
    cycles(1);
    reset_n = 1'b0;
    cycles(1);
    n_checks++; if (btn2[7] !== 1'b0) begin n_fail++; $display("FAIL coin_reset_abort: got %b want %b", btn2[7], 1'b0); end
    reset_n = 1'b1;
    cycles(3);
    n_checks++; if (btn2[7] !== 1'b0) begin n_fail++; $display("FAIL coin_after_reset: got %b want %b", btn2[7], 1'b0); end
  endtask

  task automatic test_random();
    logic [7:0] codes [12];
    codes = '{8'h75, 8'h72, 8'h29, 8'h14, 8'h16, 8'h1E, 8'h2E, 8'h36, 8'h2B, 8'h1C, 8'h2C, 8'h05};
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] code;
        code = ($urandom_range(0, 7) == 0) ? 8'($urandom) : codes[$urandom_range(0, 11)];
        send_key(1'($urandom), ($urandom_range(0, 4) == 0), code);
      end else if ($urandom_range(0, 7) == 0) begin
        ps2_key[9:0] = 10'($urandom);
      end
      for (int b = 0; b < 32; b++) if ($urandom_range(0, 9) == 0) joy2[b] = ~joy2[b];
      for (int b = 0; b < 16; b++) if ($urandom_range(0, 9) == 0) joy1[b] = ~joy1[b];
      if ($urandom_range(0, 40) == 0) af2 = 2'($urandom);
      if ($urandom_range(0, 40) == 0) af1 = 1'($urandom);
      reset_n = ($urandom_range(0, 150) != 0);
      cycles(1);
      n_checks++; if (btn2 !== exp_btn2) begin n_fail++; $display("FAIL rand_btn2[%0d]: got %h want %h", cyc, btn2, exp_btn2); end
      n_checks++; if (btn1 !== exp_btn1) begin n_fail++; $display("FAIL rand_btn1[%0d]: got %h want %h", cyc, btn1, exp_btn1); end
      n_checks++; if (test2 !== exp_test) begin n_fail++; $display("FAIL rand_test2[%0d]: got %b want %b", cyc, test2, exp_test); end
      n_checks++; if (test1 !== exp_test) begin n_fail++; $display("FAIL rand_test1[%0d]: got %b want %b", cyc, test1, exp_test); end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joy2 = '0;
    joy1 = '0;
    af2  = '0;
    af1  = 1'b0;
    test_reset();
    test_key_press();
    test_p2_routing();
    test_or_merge();
    test_autofire();
    test_coin();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for arcade cores. It decodes `hps_io` PS/2 key events into latched key states and merges them with per-player joystick words. It adds per-player fire-1 autofire and a minimum-width coin pulse, then drives one registered 8-bit button vector per player into the game core. It replaces the ad-hoc per-core keyboard `always` block and its `m_*` OR logic.

## Interface
- `PLAYERS`, default 2: number of player channels, 1–4.
- `AF_HALF`, default 200000: autofire half-period in clocks, ≥1.
- `COIN_HOLD`, default 1200000: minimum coin output width in clocks, ≥1.

Ports:
- `clk_sys` in 1: system clock. One clock domain only.
- `reset_n` in 1: reset, synchronous, active-low.
- `ps2_key` in 11: hps_io key word. Bit [10] is the toggle, [9] pressed, [8] extended, [7:0] scancode.
- `joy_in` in 16*PLAYERS: per-player joystick words, player p at [16p+15:16p]. Bit mapping: [0] right, [1] left, [2] down, [3] up, [4] fire1, [5] fire2, [6] start, [7] coin.
- `autofire_en` in PLAYERS: per-player autofire enable on fire1.
- `btn` out 8*PLAYERS: per-player vector {coin, start, fire2, fire1, up, down, left, right}, player p at [8p+7:8p].
- `btn_test` out 1: test/service key state.

## Operation
Key event detection:
- `tog_q` registers `ps2_key[10]` every clock.
- An event is `ps2_key[10] != tog_q`. On an event, the matched key register is loaded with `ps2_key[9]`.
- On reset, `tog_q` loads the current `ps2_key[10]`, so no spurious event follows reset. All key registers clear.

Keymap (E = extended bit must be 1, N = must be 0, X = ignored):
- P1 directions, X: up 0x75, down 0x72, left 0x6B, right 0x74.
- P1 buttons, N: fire1 0x29, fire2 0x14.
- Start, N: start1 is 0x16 or 0x05. start2 is 0x1E or 0x06.
- Coin, N: coin1 0x2E, coin2 0x36.
- P2, N: up 0x2D, down 0x2B, left 0x23, right 0x34, fire1 0x1C, fire2 0x1B.
- Test, N: 0x2C.
- start1 and start2 are separate key registers (F1/1 and F2/2). Each key register is set or cleared independently.
- Unlisted codes are ignored.

Routing:
- PLAYERS=1: P2 keys are ignored. start2 and coin2 route to player 0.
- Players 2 and 3 take joystick input only.

Merge:
- Raw player source = key state OR joystick bit, per function.

Autofire, per player:
- When `autofire_en[p]`=0, fire1 out = raw fire1.
- When `autofire_en[p]`=1, the output is raw fire1 gated by a phase bit.
- Phase=1 on the first cycle of a press and toggles every AF_HALF clocks while held.
- The counter and phase reset (phase=1) whenever raw fire1=0.

Coin stretch, per player:
- A rising edge of raw coin loads `cnt`=COIN_HOLD. A retrigger while nonzero reloads.
- Otherwise `cnt` decrements to 0 and saturates there.
- Coin out = raw coin OR (cnt≠0).

All `btn`/`btn_test` bits are registered. There are no combinational input-to-output paths.

## Timing
Reset:
- `btn`=0 and `btn_test`=0 on the first edge with `reset_n`=0.
- All counters = 0, phase = 1.
- Reset asserted mid-press or mid-stretch aborts it. Outputs are 0 at that edge. After release, keys remain cleared until a new press event.

Latency:
- `ps2_key` change → key register at next edge (E1) → `btn` at E2. Latency is 2 clocks.
- `joy_in` → `btn`: 1 clock.

Events:
- At most one key event is processed per event.
- A held `ps2_key` without a toggle produces no further updates.

Simultaneous sources:
- Key and joystick are ORed. Release of one source leaves the bit set if the other is still set.

Autofire waveform:
- With a continuous hold starting at edge T, fire1 out is 1 for AF_HALF clocks, then 0 for AF_HALF, repeating.

Coin waveform:
- A 1-clock coin pulse gives a coin out high for COIN_HOLD+1 clocks.

Counter widths:
- `$clog2(param+1)`. No wrap: counters saturate at 0 or reload.

## Test plan
- **Reset:** reset with `ps2_key[10]`=1 → no event. After release, all `btn`=0.
- **Key press/release:** key {toggle, pressed=1, code 0x75} → `btn[3]`=1 two clocks later. Toggle again with pressed=0 → `btn[3]`=0. Repeat with ext=1: same result. Code 0x14 with ext=1 → no change.
- **P2 routing:**
  - PLAYERS=2, press 0x2B → `btn[10]`=1 and `btn[2]`=0.
  - PLAYERS=1, press 0x36 → `btn[7]` stretches.
- **OR-merge:** P1 key up held, `joy_in[3]` pulses 1→0 → `btn[3]` stays 1. Release key → 0 after 2 clocks.
- **Autofire:** AF_HALF=4, `autofire_en[0]`=1, hold `joy_in[4]` for 20 clocks → fire1 pattern 1111 0000 1111 0000 1111, then 0 one clock after release.
- **Coin stretch:** COIN_HOLD=10, 1-clock `joy_in[7]` → coin out high 11 clocks. A second pulse at clock 5 → high until clock 16. Assert reset at clock 3 → coin 0 at that edge.
